// File: rtl/fbra_pkg.sv
// Shared definitions for the FBRA channel sequencer: FSM encoding, beamforming
// mode constants and a width helper used to size index and address buses.
package fbra_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } fbra_state_e;

  localparam logic MODE_DAS  = 1'b0;
  localparam logic MODE_DMAS = 1'b1;

  // Ceiling log2 with a floor of 1, so a single-entry range still gets a 1-bit bus.
  function automatic int fbra_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fbra_sample_ram.sv
// Simple dual-port sample buffer: one write port, one synchronous read port.
// A read and write to the same address in the same cycle returns the new data,
// so a frame started in the cycle its data is written sees that data.
module fbra_sample_ram #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 16,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array write port.
  // NOTE: the array has no reset; clearing it would force it into flops instead of RAM,
  // and sample contents are defined by the write port, not by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, write-first on an address collision; cleared on reset
  // so the sample output reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/fbra_channel_sequencer.sv
// Channel-sample sequencer for the FBRA beamforming core. Streams a buffered
// frame pixel by pixel, channels in descending order, over valid/ready.
module fbra_channel_sequencer
  import fbra_pkg::*;
#(
  parameter int CHANNELS = 128,
  parameter int PIXELS   = 4,
  parameter int DATA_W   = 16,
  parameter int CH_W     = fbra_clog2(CHANNELS),
  parameter int PX_W     = fbra_clog2(PIXELS),
  parameter int AW       = fbra_clog2(PIXELS * CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode_in,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]          out_chan,
  output logic [PX_W-1:0]          out_pixel,
  output logic                     out_last_ch,
  output logic                     out_last_px,
  output logic                     out_mode,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int            DEPTH   = PIXELS * CHANNELS;
  localparam logic [CH_W-1:0] CH_MAX  = CH_W'(CHANNELS - 1);
  localparam logic [PX_W-1:0] PX_MAX  = PX_W'(PIXELS - 1);
  localparam logic [AW-1:0]   CH_STEP = AW'(CHANNELS);
  localparam logic [AW:0]     DEPTH_X = (AW + 1)'(DEPTH);

  fbra_state_e       state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [PX_W-1:0]   pix_q, pix_d;
  logic [AW-1:0]     base_q, base_d;
  logic              mode_q, mode_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              handshake;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_data;

  assign handshake = out_valid_q & out_ready;
  // Writes are only taken while idle and inside the buffer.
  assign wr_ok     = wr_en & ~busy_q & ({1'b0, wr_addr} < DEPTH_X);
  // Address follows the next indices so the read lands with the index update.
  assign rd_addr   = base_d + AW'(ch_d);

  // Next-state logic: frame control, index advance and read issue.
  // NOTE: every signal gets a default at the top so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    pix_d       = pix_q;
    base_d      = base_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = busy_q & (start | wr_en);
    rd_en       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRIME;
          mode_d  = mode_in;
          pix_d   = '0;
          ch_d    = CH_MAX;
          base_d  = '0;
          busy_d  = 1'b1;
          rd_en   = 1'b1;
        end
      end
      ST_PRIME: begin
        state_d     = ST_STREAM;
        out_valid_d = 1'b1;
      end
      ST_STREAM: begin
        if (handshake) begin
          if (ch_q == '0) begin
            if (pix_q == PX_MAX) begin
              state_d     = ST_DONE;
              out_valid_d = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
            end else begin
              pix_d  = pix_q + PX_W'(1);
              ch_d   = CH_MAX;
              base_d = base_q + CH_STEP;
              rd_en  = 1'b1;
            end
          end else begin
            ch_d  = ch_q - CH_W'(1);
            rd_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      pix_q       <= '0;
      base_q      <= '0;
      mode_q      <= MODE_DAS;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      pix_q       <= pix_d;
      base_q      <= base_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  fbra_sample_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign out_valid   = out_valid_q;
  assign out_data    = rd_data;
  assign out_chan    = ch_q;
  assign out_pixel   = pix_q;
  assign out_last_ch = out_valid_q & (ch_q == '0);
  assign out_last_px = out_valid_q & (pix_q == PX_MAX);
  assign out_mode    = mode_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fbra_channel_sequencer.sv
// Directed bench: a 4-channel x 2-pixel sequencer for streaming, backpressure,
// mode latching, error and reset cases, and a 1x1 sequencer for the degenerate frame.
module tb_fbra_channel_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // 4 channels x 2 pixels instance
  logic        start, mode_in, wr_en, out_ready;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        out_valid, out_last_ch, out_last_px, out_mode, busy, done, err;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic [0:0]  out_pixel;

  // 1 channel x 1 pixel instance
  logic        s_start, s_mode_in, s_wr_en, s_out_ready;
  logic [0:0]  s_wr_addr;
  logic [15:0] s_wr_data;
  logic        s_out_valid, s_out_last_ch, s_out_last_px, s_out_mode, s_busy, s_done, s_err;
  logic [15:0] s_out_data;
  logic [0:0]  s_out_chan;
  logic [0:0]  s_out_pixel;

  fbra_channel_sequencer #(
    .CHANNELS(4), .PIXELS(2), .DATA_W(16), .CH_W(2), .PX_W(1), .AW(3)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_pixel(out_pixel),
    .out_last_ch(out_last_ch), .out_last_px(out_last_px),
    .out_mode(out_mode), .busy(busy), .done(done), .err(err)
  );

  fbra_channel_sequencer #(
    .CHANNELS(1), .PIXELS(1), .DATA_W(16), .CH_W(1), .PX_W(1), .AW(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(s_start), .mode_in(s_mode_in),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_chan(s_out_chan), .out_pixel(s_out_pixel),
    .out_last_ch(s_out_last_ch), .out_last_px(s_out_last_px),
    .out_mode(s_out_mode), .busy(s_busy), .done(s_done), .err(s_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        valid;
    logic [15:0] data;
    logic [1:0]  chan;
    logic        pix;
    logic        lch;
    logic        lpx;
    logic        busy;
    logic        done;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, int d, int c, int p,
                              logic lc, logic lp, logic b, logic dn);
    vec_t x;
    x.ready = r; x.valid = v; x.data = 16'(d); x.chan = 2'(c); x.pix = 1'(p);
    x.lch = lc; x.lpx = lp; x.busy = b; x.done = dn;
    return x;
  endfunction

  // Expected stream for buffer contents mem[a] = a + 100.
  function automatic logic [15:0] exp_data(input int idx);
    return 16'(100 + (idx / 4) * 4 + (3 - idx % 4));
  endfunction

  task automatic load_frame();
    for (int a = 0; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 16'(100 + a);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  // Issues start with the given mode, flips mode_in right after, checks PRIME and first valid.
  task automatic start_frame(input logic mode);
    start = 1'b1; mode_in = mode;
    @(negedge clk);
    start = 1'b0; mode_in = ~mode;
    check("prime_busy", 32'(busy), 32'd1);
    check("prime_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("first_valid", 32'(out_valid), 32'd1);
  endtask

  // Streams one frame; pat 0 = ready always, pat 1 = ready 1,0,0 repeating.
  task automatic stream(input int pat, input logic exp_mode, input bit inject);
    int  idx;
    int  errs;
    logic rdy;
    idx = 0; errs = 0;
    for (int cyc = 0; cyc < 200 && idx < 8; cyc++) begin
      errs += int'(err);
      check("s_valid", 32'(out_valid), 32'd1);
      check("s_data", 32'(out_data), 32'(exp_data(idx)));
      check("s_chan", 32'(out_chan), 32'(3 - idx % 4));
      check("s_pixel", 32'(out_pixel), 32'(idx / 4));
      check("s_last_ch", 32'(out_last_ch), 32'(idx % 4 == 3));
      check("s_last_px", 32'(out_last_px), 32'(idx / 4 == 1));
      check("s_mode", 32'(out_mode), 32'(exp_mode));
      check("s_busy", 32'(busy), 32'd1);
      if (inject) begin
        start = (cyc == 2);
        wr_en = (cyc == 3); wr_addr = 3'd5; wr_data = 16'h7fff;
      end
      rdy = (pat == 0) ? 1'b1 : (cyc % 3 == 0);
      out_ready = rdy;
      if (rdy) idx++;
      @(negedge clk);
    end
    start = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
    check("frame_len", 32'(idx), 32'd8);
    errs += int'(err);
    check("done_pulse", 32'(done), 32'd1);
    check("done_valid", 32'(out_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    errs += int'(err);
    check("done_clear", 32'(done), 32'd0);
    check("err_count", 32'(errs), inject ? 32'd2 : 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_chan"}, 32'(out_chan), 32'd0);
    check({tag, "_pixel"}, 32'(out_pixel), 32'd0);
    check({tag, "_flags"}, {28'd0, out_last_ch, out_last_px, out_mode, busy}, 32'd0);
    check({tag, "_pulses"}, {30'd0, done, err}, 32'd0);
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = mk(1, 0,   0, 0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(1, 1, 103, 3, 0, 0, 0, 1, 0);
    tbl[2]  = mk(1, 1, 102, 2, 0, 0, 0, 1, 0);
    tbl[3]  = mk(1, 1, 101, 1, 0, 0, 0, 1, 0);
    tbl[4]  = mk(1, 1, 100, 0, 0, 1, 0, 1, 0);
    tbl[5]  = mk(1, 1, 107, 3, 1, 0, 1, 1, 0);
    tbl[6]  = mk(1, 1, 106, 2, 1, 0, 1, 1, 0);
    tbl[7]  = mk(1, 1, 105, 1, 1, 0, 1, 1, 0);
    tbl[8]  = mk(1, 1, 104, 0, 1, 1, 1, 1, 0);
    tbl[9]  = mk(0, 0,   0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, 0,   0, 0, 0, 0, 0, 0, 0);

    rst = 1'b0;
    start = 0; mode_in = 0; wr_en = 0; wr_addr = '0; wr_data = '0; out_ready = 0;
    s_start = 0; s_mode_in = 0; s_wr_en = 0; s_wr_addr = '0; s_wr_data = '0; s_out_ready = 0;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    check("rst1_valid_busy", {30'd0, s_out_valid, s_busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Full-throughput frame from the vector table.
    load_frame();
    start = 1'b1; mode_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    foreach (tbl[i]) begin
      check($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].valid));
      check($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("t%0d_done", i), 32'(done), 32'(tbl[i].done));
      if (tbl[i].valid) begin
        check($sformatf("t%0d_data", i), 32'(out_data), 32'(tbl[i].data));
        check($sformatf("t%0d_chan", i), 32'(out_chan), 32'(tbl[i].chan));
        check($sformatf("t%0d_pix", i), 32'(out_pixel), 32'(tbl[i].pix));
        check($sformatf("t%0d_lch", i), 32'(out_last_ch), 32'(tbl[i].lch));
        check($sformatf("t%0d_lpx", i), 32'(out_last_px), 32'(tbl[i].lpx));
      end
      out_ready = tbl[i].ready;
      @(negedge clk);
    end
    out_ready = 1'b0;

    // Backpressure with ready 1,0,0 repeating.
    start_frame(1'b0);
    stream(1, 1'b0, 1'b0);

    // Mode latched at start, then a DAS frame.
    start_frame(1'b1);
    stream(0, 1'b1, 1'b0);
    start_frame(1'b0);
    stream(0, 1'b0, 1'b0);

    // start and wr_en while busy: two err pulses, stream and buffer untouched.
    start_frame(1'b0);
    stream(0, 1'b0, 1'b1);

    // Reset after the third handshake, then replay from the top.
    start_frame(1'b1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_data", 32'(out_data), 32'd100);
    rst = 1'b0; out_ready = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    check_all_zero("midrst_hold");
    rst = 1'b1;
    @(negedge clk);
    start_frame(1'b0);
    stream(0, 1'b0, 1'b0);

    // 1x1 frame; the start-cycle write must be seen by the frame.
    s_wr_en = 1'b1; s_wr_addr = 1'b0; s_wr_data = 16'd42;
    @(negedge clk);
    s_wr_data = 16'hfffb; s_start = 1'b1; s_mode_in = 1'b1;
    @(negedge clk);
    s_wr_en = 1'b0; s_start = 1'b0; s_mode_in = 1'b0;
    check("one_prime", {30'd0, s_out_valid, s_busy}, 32'd1);
    @(negedge clk);
    check("one_valid", 32'(s_out_valid), 32'd1);
    check("one_data", 32'(s_out_data), 32'h0000fffb);
    check("one_idx", {30'd0, s_out_chan, s_out_pixel}, 32'd0);
    check("one_last", {30'd0, s_out_last_ch, s_out_last_px}, 32'd3);
    check("one_mode", 32'(s_out_mode), 32'd1);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    check("one_done", {29'd0, s_done, s_out_valid, s_busy}, 32'd4);
    check("one_last_clr", {30'd0, s_out_last_ch, s_out_last_px}, 32'd0);
    @(negedge clk);
    check("one_done_clr", 32'(s_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
